// File: rtl/seq_mult_div_pkg.sv
// Shared constants for the iterative signed multiply/divide unit:
// default operand width, operation encodings and FSM state codes.
package seq_mult_div_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // Operation select on the op port
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // FSM state codes
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MULT = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/seq_mult_div_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the
// multiplicand into the accumulator, then an arithmetic right shift of
// the combined {acc, q, q_m1} register.
module booth_step
  import seq_mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);

  logic [WIDTH:0] acc_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] sum;

  // The sum is one bit wider than acc so that subtracting the most
  // negative multiplicand cannot wrap before the shift brings it back.
  always_comb begin
    acc_ext = {acc[WIDTH-1], acc};
    b_ext   = {b[WIDTH-1], b};
    case ({q[0], q_m1})
      2'b01:   sum = acc_ext + b_ext;
      2'b10:   sum = acc_ext - b_ext;
      default: sum = acc_ext;
    endcase
    acc_next  = sum[WIDTH:1];
    q_next    = {sum[0], q[WIDTH-1:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/seq_mult_div.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring on
// magnitudes plus a sign-fix cycle) producing HI/LO for the datapath.
module seq_mult_div
  import seq_mult_div_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  logic [2:0]       state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH-1:0] b_reg;
  logic             sign_a;
  logic             sign_b;
  logic             dz_flag;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic [WIDTH-1:0] booth_acc;
  logic [WIDTH-1:0] booth_q;
  logic             booth_q_m1;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;
  logic             accept;

  booth_step #(.WIDTH(WIDTH)) u_booth_step (
    .acc       (acc),
    .q         (q),
    .q_m1      (q_m1),
    .b         (b_reg),
    .acc_next  (booth_acc),
    .q_next    (booth_q),
    .q_m1_next (booth_q_m1)
  );

  // Operand magnitudes for divide; the most negative value maps onto
  // itself, which read as unsigned is exactly its magnitude.
  always_comb begin
    a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
    b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
    accept = start && ((state == ST_IDLE) || (state == ST_DONE));
  end

  // One restoring divide step: shift the next dividend bit into the
  // remainder, trial-subtract the divisor, keep the old remainder if
  // the trial went negative.
  always_comb begin
    div_shift = {acc, q[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_reg};
    rem_next  = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    quot_next = {q[WIDTH-2:0], ~div_trial[WIDTH]};
  end

  // Main FSM and datapath registers; acc/q are shared between the
  // Booth product and the remainder/quotient of the divide.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      acc     <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      b_reg   <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      dz_flag <= 1'b0;
      hi_reg  <= '0;
      lo_reg  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          dz_flag <= 1'b0;
          state   <= ST_IDLE;
          if (accept) begin
            acc     <= '0;
            q_m1    <= 1'b0;
            counter <= CNT_W'(WIDTH - 1);
            if (op == OP_DIV) begin
              sign_a <= a[WIDTH-1];
              sign_b <= b[WIDTH-1];
              q      <= a_mag;
              b_reg  <= b_mag;
              if (b == '0) begin
                state   <= ST_DONE;
                dz_flag <= 1'b1;
              end else begin
                state <= ST_DIV;
              end
            end else begin
              q     <= a;
              b_reg <= b;
              state <= ST_MULT;
            end
          end
        end
        ST_MULT: begin
          acc  <= booth_acc;
          q    <= booth_q;
          q_m1 <= booth_q_m1;
          if (counter == '0) begin
            hi_reg <= booth_acc;
            lo_reg <= booth_q;
            state  <= ST_DONE;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        ST_DIV: begin
          acc <= rem_next;
          q   <= quot_next;
          if (counter == '0) begin
            state <= ST_FIX;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        ST_FIX: begin
          lo_reg <= (sign_a ^ sign_b) ? (~q + 1'b1) : q;
          hi_reg <= sign_a ? (~acc + 1'b1) : acc;
          state  <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs decode directly from the state register
  always_comb begin
    busy     = (state == ST_MULT) || (state == ST_DIV) || (state == ST_FIX);
    done     = (state == ST_DONE);
    div_zero = (state == ST_DONE) && dz_flag;
    hi       = hi_reg;
    lo       = lo_reg;
  end

endmodule

// File: tb/tb_seq_mult_div.sv
// Self-checking bench for seq_mult_div: directed vector table, random
// operations against an arithmetic reference, and multi-cycle corner
// sequences (back-to-back, ignored restart, mid-operation reset).
module tb_seq_mult_div;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  int tests  = 0;
  int failed = 0;

  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int           exp_lat;
    logic         exp_dz;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  seq_mult_div #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive a start pulse for one edge, then scramble a/b to prove capture
  task automatic apply_stimulus(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Cycle n0 is the current cycle counted from the accepting edge
  task automatic wait_done(input int n0, output int lat, output bit busy_ok);
    int n;
    n       = n0;
    busy_ok = 1'b1;
    while (!done && n < 60) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    lat = n;
    if (busy) busy_ok = 1'b0;
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward
  // zero and the remainder follows the dividend's sign.
  function automatic void ref_model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                    inout logic [W-1:0] h, inout logic [W-1:0] l,
                                    output int lat, output logic dz);
    longint sx, sy, p, qq, rr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0;
    if (o == 1'b0) begin
      p   = sx * sy;
      h   = p[63:32];
      l   = p[31:0];
      lat = 33;
    end else if (y == '0) begin
      lat = 1;
      dz  = 1'b1;
    end else begin
      qq  = sx / sy;
      rr  = sx % sy;
      l   = qq[31:0];
      h   = rr[31:0];
      lat = 34;
    end
  endfunction

  task automatic run_and_check(input string tag, input logic o, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [W-1:0] exp_hi,
                               input logic [W-1:0] exp_lo, input int exp_lat, input logic exp_dz);
    int lat;
    bit busy_ok;
    apply_stimulus(o, x, y);
    wait_done(1, lat, busy_ok);
    check_output({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_output({tag, " busy window"}, 64'(busy_ok), 64'd1);
    check_output({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
    check_output({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check_output({tag, " lo"}, 64'(lo), 64'(exp_lo));
    @(posedge clk);
    #1;
    check_output({tag, " done/div_zero drop"}, {62'd0, done, div_zero}, 64'd0);
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  initial begin
    logic [W-1:0] eh, el, x, y;
    logic         o, edz;
    int           elat, lat;
    bit           busy_ok;

    vecs[0] = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0};
    vecs[1] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 1'b0};
    vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 1'b0};
    vecs[4] = '{1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1,  1'b1};
    vecs[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 1'b0};
    vecs[6] = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       34, 1'b0};
    vecs[7] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 34, 1'b0};
    vecs[8] = '{1'b0, 32'd0,        32'd12345,    32'd0,        32'd0,        33, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset busy/done/dz", {61'd0, busy, done, div_zero}, 64'd0);
    check_output("reset hi/lo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_lat, vecs[i].exp_dz);
    end

    for (int i = 0; i < 30; i++) begin
      o = 1'(($urandom_range(0, 1)));
      x = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 50)) : W'($urandom);
      if ($urandom_range(0, 7) == 0)      y = '0;
      else if ($urandom_range(0, 1) == 0) y = W'($urandom_range(0, 20)) - W'(10);
      else                                y = W'($urandom);
      eh = model_hi;
      el = model_lo;
      ref_model(o, x, y, eh, el, elat, edz);
      run_and_check($sformatf("rand%0d", i), o, x, y, eh, el, elat, edz);
    end

    // Back-to-back: second start accepted during the DONE cycle
    apply_stimulus(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1, lat, busy_ok);
    check_output("b2b first lo", 64'(lo), 64'h80000000);
    check_output("b2b first hi", 64'(hi), 64'h0);
    apply_stimulus(1'b1, 32'd100, 32'd7);
    wait_done(1, lat, busy_ok);
    check_output("b2b second latency", 64'(lat), 64'd34);
    check_output("b2b second busy window", 64'(busy_ok), 64'd1);
    check_output("b2b second lo", 64'(lo), 64'd14);
    check_output("b2b second hi", 64'(hi), 64'd2);
    @(posedge clk);
    #1;

    // Restart pulse in the middle of a multiply must be ignored
    eh = model_hi;
    el = model_lo;
    ref_model(1'b0, 32'd1234, 32'hFFFFFFC8, eh, el, elat, edz);
    apply_stimulus(1'b0, 32'd1234, 32'hFFFFFFC8);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    op    = 1'b1;
    a     = 32'd9;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(11, lat, busy_ok);
    check_output("repulse latency", 64'(lat), 64'(elat));
    check_output("repulse busy window", 64'(busy_ok), 64'd1);
    check_output("repulse hi/lo", {hi, lo}, {eh, el});
    @(posedge clk);
    #1;

    // Reset in the middle of a divide discards it and clears outputs
    apply_stimulus(1'b1, 32'd1000, 32'd3);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("midreset busy/done", {62'd0, busy, done}, 64'd0);
    check_output("midreset hi/lo", {hi, lo}, 64'd0);
    model_hi = '0;
    model_lo = '0;
    eh = model_hi;
    el = model_lo;
    ref_model(1'b1, 32'hFFFFFC18, 32'd7, eh, el, elat, edz);
    run_and_check("post-reset div", 1'b1, 32'hFFFFFC18, 32'd7, eh, el, elat, edz);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seq_mult_div.md
Name: seq_mult_div

Overview:
Iterative signed multiply/divide unit for the multicycle datapath. It consumes the latched A/B register operands and produces the HI/LO values that the HI and LO registers capture.
- Multiply: radix-2 Booth, 32 iterations.
- Divide: signed restoring, 32 iterations, then one sign-fix cycle.
- The control unit pulses start, waits on busy, and writes HI/LO on done.

Parameters:
WIDTH, 32, operand width; HI/LO each WIDTH bits; iteration count = WIDTH.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only when not busy.
op  input  1  0 = signed multiply, 1 = signed divide.
a  input  WIDTH  multiplicand / dividend (A register).
b  input  WIDTH  multiplier / divisor (B register).
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse: operation finished, hi/lo valid.
hi  output  WIDTH  multiply: upper product word; divide: remainder.
lo  output  WIDTH  multiply: lower product word; divide: quotient.
div_zero  output  1  one-cycle pulse with done when a divide had b == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset (also mid-operation): state IDLE, counter 0, internal accumulators 0, busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0. Any operation in flight is discarded.
- States: IDLE, MULT, DIV, FIX, DONE.
- Operand capture: start is accepted in IDLE or DONE. a and b are captured at the accepting edge; later changes on a/b are ignored.
- start in MULT/DIV/FIX is ignored: no queueing, no effect on the current operation.
- Multiply:
  - Init: acc = 0, q = a, q_-1 = 0.
  - Each MULT cycle, on the pair {q[0], q_-1}: 01 -> acc += b; 10 -> acc -= b.
  - Then arithmetic right shift of {acc, q, q_-1}.
  - 32 MULT cycles, then DONE. Result: hi = acc, lo = q (64-bit two's-complement product).
  - Timing: start sampled at edge k -> busy high in cycles k+1..k+32 -> done at cycle k+33.
- Divide:
  - Latch the signs of a and b. Divide the magnitudes |a|, |b| as unsigned, 32 restoring steps (shift left, trial subtract, restore on negative).
  - FIX: quotient negated if sign(a) != sign(b); remainder takes the sign of a.
  - Rounding: quotient truncates toward zero.
  - Timing: busy high k+1..k+33 (32 DIV + 1 FIX) -> done at cycle k+34.
- Overflow case: a = 0x80000000, b = 0xFFFFFFFF gives lo = 0x80000000, hi = 0, no flag.
  - |0x80000000| is treated as unsigned 2^31; no special path is needed.
- Divide by zero: op = 1 and b == 0 at acceptance goes directly to DONE.
  - done = 1 and div_zero = 1 at cycle k+1, busy never rises.
  - hi/lo keep their previous values.
- DONE lasts exactly 1 cycle, then IDLE unless start is accepted in DONE; back-to-back is allowed.
- In DONE: busy = 0, done = 1.
- hi/lo are registered and update only on the edge entering DONE (except divide by zero); they hold until the next completion or reset.
- done and div_zero are never high outside DONE.
- The counter counts down from WIDTH-1 to 0. The last iteration is taken in the cycle where counter == 0; no wrap is exposed.

Decomposition:
- Shared package: state enum (IDLE, MULT, DIV, FIX, DONE), op encodings (OP_MULT = 0, OP_DIV = 1), WIDTH default constant.
- One natural sub-module, booth_step: combinational single Booth iteration (acc, q, q_-1, b) -> next (acc, q, q_-1). Unit-testable on its own.
- The divide step stays inline.

Test Plan:
- Multiply, small signed: op = 0, a = 7, b = 0xFFFFFFFD (-3), start at k -> done only at k+33, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high k+1..k+32.
- Multiply, extreme: a = b = 0x80000000 -> hi = 0x40000000, lo = 0x00000000. Then a = 0xFFFFFFFF, b = 0xFFFFFFFF -> hi = 0, lo = 1.
- Divide, negative dividend: op = 1, a = 0xFFFFFFF9 (-7), b = 2 -> done at k+34, lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
- Divide by zero: a = 5, b = 0 -> done = div_zero = 1 at k+1 only, busy never high. hi/lo unchanged from the prior result.
- Divide overflow and back-to-back: a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0. Then start asserted in DONE with a = 100, b = 7 -> lo = 14, hi = 2 exactly 34 cycles later.
- Robustness: start re-pulsed with new a/b at k+10 of a multiply -> ignored, result matches the original operands. Then reset at k+5 of a second operation -> next cycle busy = done = 0, hi = lo = 0; a fresh start completes normally.
